pipelined_adder_tree: RTL and testbench
=======================================

# pipelined_adder_tree

Pipelined, parametrised reduction tree that sums `NUM_INPUTS` operands of `DATA_WIDTH` bits into one full-precision result. This is the registered successor to the combinational balanced adder. It accepts any operand count, not only powers of two, and supports signed or unsigned arithmetic. It registers every tree level and uses a valid/ready handshake on both sides. It sits behind the partial-product generator in the multiplier datapath and feeds the final normalisation stage.

## Interface
- `NUM_INPUTS`, default 16: operand count, must be at least 1, any integer.
- `DATA_WIDTH`, default 8: width of each operand.
- `SIGNED`, default 0: 1 = two's-complement operands with sign extension; 0 = unsigned with zero extension.
- `LEVELS` (derived, not overridable): `$clog2(NUM_INPUTS)`; the stage count is `STAGES = max(1, LEVELS)`.
- `SUM_WIDTH` (derived): `DATA_WIDTH + LEVELS`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: operand vector is valid.
- `in_ready`, output, 1: tree accepts the operand vector this cycle.
- `inputs`, input, `[NUM_INPUTS-1:0][DATA_WIDTH-1:0]`: operand vector.
- `out_valid`, output, 1: `out_sum` holds a result.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, `SUM_WIDTH`: reduced sum.
- `out_sat`, output, 1: the result was clamped (see Configuration).

## Operation
- Operands are extended to `SUM_WIDTH` on entry. The extension is sign extension when `SIGNED=1` and zero extension otherwise.
- Level k takes n_k values and produces ceil(n_k/2) values.
  - Element pairs (2i, 2i+1) are added.
  - When n_k is odd, the last element passes through unchanged and stays in the highest index.
- Each level ends in a register. Per-stage valid bits travel alongside the data.
- All arithmetic is done at `SUM_WIDTH`. Overflow is impossible by construction, so the result is exact.
- `NUM_INPUTS=1`: a single register stage. `out_sum` is the extended operand.
- Flow control uses a global stall, with `advance = out_ready || !out_valid`.
  - `in_ready = advance`, combinational, with no dependence on `in_valid`.
  - When `advance=1`, every stage loads from its predecessor, and stage 0 loads `in_valid`/`inputs`.
  - When `advance=0`, all stages hold their data and valid bits.
  - Bubbles are not squeezed out. Interior invalid stages still shift only on `advance`.
- A transfer happens on a cycle where valid and ready are both high. Results leave in acceptance order.

## Timing
- Latency is `STAGES` cycles from input transfer to `out_valid`, assuming no stall.
  - Example: `NUM_INPUTS=16` gives 4 cycles. `NUM_INPUTS=5` gives 3 cycles.
- Throughput is one vector per cycle while `out_ready=1`.
- Stall: while `out_valid=1` and `out_ready=0`:
  - `out_sum` and `out_sat` are stable;
  - `in_ready=0`;
  - no data is lost.
- Reset is asynchronous. It clears all valid bits, `out_sum=0` and `out_sat=0` immediately.
  - Data registers may also be cleared.
  - Results in flight when reset asserts mid-operation are discarded.
  - `in_ready=1` after reset.
- Simultaneous output drain and input accept in the same cycle is legal. It is the normal full-rate case.
- `inputs` is sampled only on a transfer cycle. Values outside transfer cycles are don't-care.

## Configuration
- `ADDER_TREE_SAT_EN` defined: the output stage clamps the exact sum to the `DATA_WIDTH` range.
  - Signed range: [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Unsigned range: [0, 2^DATA_WIDTH-1].
  - The clamped value is extended to `SUM_WIDTH` using the same signedness rule.
  - `out_sat=1` whenever clamping occurred for that result.
  - Latency is unchanged; the clamp is inside the last register stage.
- `ADDER_TREE_SAT_EN` not defined: `out_sum` is the exact sum and `out_sat` is tied to 0.

## Structure
- Package `adder_tree_pkg` holds:
  - the `clog2`-based level and width helper functions;
  - a function returning the element count at level k;
  - the saturation-bound helper functions.
- Sub-module `adder_tree_level` implements one registered level. It takes the element count in, the width and the signedness as parameters, and carries data, a valid bit and an advance enable.
  - The top module instantiates it `STAGES` times with a generate loop.
  - The top module adds the handshake logic and the optional saturation logic.

## Test plan
- Reset, then `NUM_INPUTS=16`, `DATA_WIDTH=8`, unsigned, all operands 0xFF, `out_ready=1` -> after 4 cycles `out_valid=1`, `out_sum=0xFF0` (12 bits).
- `NUM_INPUTS=5`, `SIGNED=1`, operands {-128,-128,-128,-128,-128} -> `out_sum=-640`, 11 bits (0x580), after 3 cycles.
- Back-to-back vectors 1..20, each with all operands = n, `NUM_INPUTS=4`, `out_ready=1` -> 20 consecutive results 4n in order, one per cycle.
- Hold `out_ready=0` for 6 cycles with the pipe full -> `in_ready=0`, `out_sum` stable; after release no result is lost or duplicated.
- Assert `rst_n=0` mid-stream with 3 results in flight -> `out_valid` drops immediately, and no stale result appears after release.
- With `ADDER_TREE_SAT_EN`, `SIGNED=1`, `DATA_WIDTH=8`, operands {100,100} -> `out_sum=127`, `out_sat=1`. Operands {-100,-100} -> -128, `out_sat=1`. Operands {10,20} -> 30, `out_sat=0`.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level/stage/width arithmetic,
// per-level element counts and the saturation bounds used by the output stage.
package adder_tree_pkg;

    // Number of pairwise reduction levels needed for n operands.
    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Register stages: a single operand still gets one registered stage.
    function automatic int tree_stages(input int n);
        return (tree_levels(n) == 0) ? 1 : tree_levels(n);
    endfunction

    // Full-precision result width for n operands of dw bits.
    function automatic int tree_sum_width(input int dw, input int n);
        return dw + tree_levels(n);
    endfunction

    // Element count entering level k (level 0 sees all n operands).
    function automatic int level_count(input int n, input int k);
        int c = n;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Largest value representable in dw bits with the given signedness.
    function automatic longint sat_max(input int dw, input bit is_signed);
        return is_signed ? ((longint'(1) <<< (dw - 1)) - 1) : ((longint'(1) <<< dw) - 1);
    endfunction

    // Smallest value representable in dw bits with the given signedness.
    function automatic longint sat_min(input int dw, input bit is_signed);
        return is_signed ? -(longint'(1) <<< (dw - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: extends its inputs to the output width,
// adds neighbouring pairs (an odd last element passes through in the top
// slot), optionally clamps element 0, and registers the result on advance.
// The sat flag rides along with the data so the final stage can report it.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 9,
    parameter bit SIGNED    = 1'b0,
    parameter bit SAT_EN    = 1'b0,
    parameter int SAT_WIDTH = 8,
    localparam int N_OUT    = (N_IN + 1) / 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 advance,
    input  logic                                 in_valid,
    input  logic                                 in_sat,
    input  logic [N_IN-1:0][IN_WIDTH-1:0]        in_data,
    output logic                                 out_valid,
    output logic                                 out_sat,
    output logic [N_OUT-1:0][OUT_WIDTH-1:0]      out_data
);

    localparam logic signed [OUT_WIDTH:0] SAT_HI = (OUT_WIDTH + 1)'(sat_max(SAT_WIDTH, SIGNED));
    localparam logic signed [OUT_WIDTH:0] SAT_LO = (OUT_WIDTH + 1)'(sat_min(SAT_WIDTH, SIGNED));

    logic [N_IN-1:0][OUT_WIDTH-1:0]  ext;
    logic [N_OUT-1:0][OUT_WIDTH-1:0] sum;
    logic [N_OUT-1:0][OUT_WIDTH-1:0] next_data;
    logic                            next_sat;
    logic signed [OUT_WIDTH:0]       wide;

    genvar i;

    // Bring every operand up to the working width before any addition.
    for (i = 0; i < N_IN; i++) begin : g_ext
        if (SIGNED) begin : g_sign
            assign ext[i] = OUT_WIDTH'($signed(in_data[i]));
        end else begin : g_zero
            assign ext[i] = OUT_WIDTH'(in_data[i]);
        end
    end

    // Pairwise sums; an unpaired last element is forwarded unchanged.
    for (i = 0; i < N_OUT; i++) begin : g_pair
        if (2 * i + 1 < N_IN) begin : g_add
            assign sum[i] = ext[2*i] + ext[2*i+1];
        end else begin : g_pass
            assign sum[i] = ext[2*i];
        end
    end

    // Optional clamp of element 0 (only enabled on the single-element final level).
    always_comb begin
        next_data = sum;
        next_sat  = in_sat;
        wide      = SIGNED ? {sum[0][OUT_WIDTH-1], sum[0]} : {1'b0, sum[0]};
        if (SAT_EN) begin
            next_sat = 1'b0;
            if (wide > SAT_HI) begin
                next_data[0] = SAT_HI[OUT_WIDTH-1:0];
                next_sat     = 1'b1;
            end else if (wide < SAT_LO) begin
                next_data[0] = SAT_LO[OUT_WIDTH-1:0];
                next_sat     = 1'b1;
            end
        end
    end

    // Level register: loads only when the whole pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_sat   <= next_sat;
            out_data  <= next_data;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined reduction tree summing NUM_INPUTS operands at full precision,
// one registered level per tree level, with a global-stall valid/ready
// handshake. Define ADDER_TREE_SAT_EN to clamp the result to the operand
// range inside the last register stage and report it on out_sat.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int  NUM_INPUTS = 16,
    parameter int  DATA_WIDTH = 8,
    parameter bit  SIGNED     = 1'b0,
    localparam int LEVELS     = tree_levels(NUM_INPUTS),
    localparam int STAGES     = tree_stages(NUM_INPUTS),
    localparam int SUM_WIDTH  = tree_sum_width(DATA_WIDTH, NUM_INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SUM_WIDTH-1:0]                  out_sum,
    output logic                                  out_sat
);

`ifdef ADDER_TREE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic advance;

    // Global stall: the pipe moves unless a result is waiting on the consumer.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_level
        localparam int N_IN  = level_count(NUM_INPUTS, k);
        localparam int N_OUT = (N_IN + 1) / 2;
        localparam int IN_W  = (k == 0) ? DATA_WIDTH : SUM_WIDTH;

        logic [N_IN-1:0][IN_W-1:0]       in_data;
        logic                            in_valid_k;
        logic                            in_sat_k;
        logic [N_OUT-1:0][SUM_WIDTH-1:0] data;
        logic                            valid;
        logic                            sat;

        if (k == 0) begin : g_first
            assign in_data    = inputs;
            assign in_valid_k = in_valid;
            assign in_sat_k   = 1'b0;
        end else begin : g_next
            assign in_data    = g_level[k-1].data;
            assign in_valid_k = g_level[k-1].valid;
            assign in_sat_k   = g_level[k-1].sat;
        end

        adder_tree_level #(
            .N_IN      (N_IN),
            .IN_WIDTH  (IN_W),
            .OUT_WIDTH (SUM_WIDTH),
            .SIGNED    (SIGNED),
            .SAT_EN    (SAT_EN && (k == STAGES - 1)),
            .SAT_WIDTH (DATA_WIDTH)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (in_valid_k),
            .in_sat    (in_sat_k),
            .in_data   (in_data),
            .out_valid (valid),
            .out_sat   (sat),
            .out_data  (data)
        );
    end

    assign out_valid = g_level[STAGES-1].valid;
    assign out_sum   = g_level[STAGES-1].data[0];
    assign out_sat   = g_level[STAGES-1].sat;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: a 5-operand signed instance
// (odd count, three stages) and a 16-operand unsigned instance (four stages).
// Drivers push hand-computed expected results; monitors pop on each output
// transfer and check value, sat flag and latency.
module tb_pipelined_adder_tree;

    localparam int STAGES_S = 3;
    localparam int STAGES_U = 4;

    logic              clk = 1'b0;
    logic              rst_n;

    logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
    logic [4:0][7:0]   s_inputs;
    logic [10:0]       s_out_sum;

    logic              u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_sat;
    logic [15:0][7:0]  u_inputs;
    logic [11:0]       u_out_sum;

    typedef struct {
        int val;
        bit sat;
        int cyc;
        bit chk_lat;
    } sb_t;

    sb_t sq_s[$];
    sb_t sq_u[$];

    int cycle      = 0;
    int pass_cnt   = 0;
    int total_cnt  = 0;

    pipelined_adder_tree #(.NUM_INPUTS(5), .DATA_WIDTH(8), .SIGNED(1'b1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .inputs    (s_inputs),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_sat   (s_out_sat)
    );

    pipelined_adder_tree #(.NUM_INPUTS(16), .DATA_WIDTH(8), .SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (u_in_valid),
        .in_ready  (u_in_ready),
        .inputs    (u_inputs),
        .out_valid (u_out_valid),
        .out_ready (u_out_ready),
        .out_sum   (u_out_sum),
        .out_sat   (u_out_sat)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Count rising edges so drivers and monitors can timestamp transfers.
    always @(posedge clk) cycle <= cycle + 1;

    // Expected output value of the signed instance for an exact sum.
    function automatic int expS(input int exact);
`ifdef ADDER_TREE_SAT_EN
        if (exact > 127) return 127;
        if (exact < -128) return -128;
`endif
        return exact;
    endfunction

    function automatic bit expSatS(input int exact);
`ifdef ADDER_TREE_SAT_EN
        return (exact > 127) || (exact < -128);
`else
        return (exact != exact);
`endif
    endfunction

    // Expected output value of the unsigned instance for an exact sum.
    function automatic int expU(input int exact);
`ifdef ADDER_TREE_SAT_EN
        if (exact > 255) return 255;
`endif
        return exact;
    endfunction

    function automatic bit expSatU(input int exact);
`ifdef ADDER_TREE_SAT_EN
        return exact > 255;
`else
        return (exact != exact);
`endif
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one vector to the signed instance and record its expected result at acceptance.
    task automatic applyStimulus(input logic [4:0][7:0] ops, input int exact, input bit chk_lat);
        sb_t e;
        int  w = 0;
        s_inputs   = ops;
        s_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_in_ready) break;
            w++;
            if (w > 50) begin
                total_cnt++;
                $display("[TB] FAIL s_accept_timeout: in_ready stayed 0, expected 1");
                s_in_valid = 1'b0;
                return;
            end
        end
        e.val = expS(exact); e.sat = expSatS(exact); e.cyc = cycle; e.chk_lat = chk_lat;
        sq_s.push_back(e);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    // Offer one vector to the unsigned instance.
    task automatic applyStimulusU(input logic [15:0][7:0] ops, input int exact, input bit chk_lat);
        sb_t e;
        int  w = 0;
        u_inputs   = ops;
        u_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (u_in_ready) break;
            w++;
            if (w > 50) begin
                total_cnt++;
                $display("[TB] FAIL u_accept_timeout: in_ready stayed 0, expected 1");
                u_in_valid = 1'b0;
                return;
            end
        end
        e.val = expU(exact); e.sat = expSatU(exact); e.cyc = cycle; e.chk_lat = chk_lat;
        sq_u.push_back(e);
        @(posedge clk); #1;
        u_in_valid = 1'b0;
    endtask

    // Wait (bounded) for both scoreboards to empty.
    task automatic waitDrain();
        int w = 0;
        while ((sq_s.size() != 0 || sq_u.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        if (sq_s.size() != 0 || sq_u.size() != 0) begin
            total_cnt++;
            $display("[TB] FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0", sq_s.size(), sq_u.size());
        end
        @(posedge clk); #1;
    endtask

    // Signed-instance monitor: on each output transfer, pop and compare.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && s_out_valid && s_out_ready) begin
            if (sq_s.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL s_unexpected: got result %0d, expected no result", $signed(s_out_sum));
            end else begin
                e = sq_s.pop_front();
                checkOutput("s_sum", int'($signed(s_out_sum)), e.val);
                checkOutput("s_sat", s_out_sat, e.sat);
                if (e.chk_lat) checkOutput("s_latency", cycle - e.cyc, STAGES_S);
            end
        end
    end

    // Unsigned-instance monitor.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && u_out_valid && u_out_ready) begin
            if (sq_u.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL u_unexpected: got result %0d, expected no result", u_out_sum);
            end else begin
                e = sq_u.pop_front();
                checkOutput("u_sum", int'(u_out_sum), e.val);
                checkOutput("u_sat", u_out_sat, e.sat);
                if (e.chk_lat) checkOutput("u_latency", cycle - e.cyc, STAGES_U);
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [15:0][7:0] uv;
        logic [7:0]       b;

        rst_n       = 1'b0;
        s_in_valid  = 1'b0;
        s_inputs    = '0;
        s_out_ready = 1'b1;
        u_in_valid  = 1'b0;
        u_inputs    = '0;
        u_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_s_out_valid", s_out_valid, 0);
        checkOutput("reset_s_out_sum", s_out_sum, 0);
        checkOutput("reset_s_in_ready", s_in_ready, 1);
        checkOutput("reset_u_out_valid", u_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed directed vectors (index 0 is the rightmost byte).
        applyStimulus({5{8'h80}}, -640, 1'b1);
        waitDrain();
        applyStimulus({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 15, 1'b1);
        applyStimulus({8'hFB, 8'd4, 8'hFD, 8'd2, 8'hFF}, -3, 1'b1);
        applyStimulus({8'd50, 8'd0, 8'd0, 8'd0, 8'd0}, 50, 1'b1);
        applyStimulus({8'd0, 8'd0, 8'd0, 8'd100, 8'd100}, 200, 1'b1);
        applyStimulus({8'd0, 8'd0, 8'd0, 8'h9C, 8'h9C}, -200, 1'b1);
        applyStimulus({8'd0, 8'd0, 8'd0, 8'd20, 8'd10}, 30, 1'b1);
        applyStimulus({5{8'h7F}}, 635, 1'b1);
        waitDrain();

        // Unsigned directed vectors.
        applyStimulusU({16{8'hFF}}, 4080, 1'b1);
        for (int i = 0; i < 16; i++) uv[i] = 8'(i);
        applyStimulusU(uv, 120, 1'b1);
        uv = '0;
        uv[15] = 8'h80;
        applyStimulusU(uv, 128, 1'b1);
        waitDrain();

        // Back-to-back stream, one vector per cycle.
        for (int n = 1; n <= 20; n++) begin
            b = 8'(n);
            applyStimulus({5{b}}, 5 * n, 1'b1);
        end
        waitDrain();

        // Fill the pipe with the consumer stalled, hold, then release.
        s_out_ready = 1'b0;
        applyStimulus({5{8'd7}}, 35, 1'b0);
        applyStimulus({5{8'hFE}}, -10, 1'b0);
        applyStimulus({8'd3, 8'd0, 8'd0, 8'd0, 8'd9}, 12, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", s_in_ready, 0);
            checkOutput("stall_out_valid", s_out_valid, 1);
            checkOutput("stall_hold_sum", int'($signed(s_out_sum)), expS(35));
        end
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        waitDrain();

        // Reset with three results in flight; none may reappear.
        applyStimulus({5{8'd1}}, 5, 1'b1);
        applyStimulus({5{8'd2}}, 10, 1'b1);
        applyStimulus({5{8'd3}}, 15, 1'b1);
        rst_n = 1'b0;
        sq_s.delete();
        #1;
        checkOutput("midreset_out_valid", s_out_valid, 0);
        checkOutput("midreset_out_sum", s_out_sum, 0);
        checkOutput("midreset_in_ready", s_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus({8'd0, 8'd0, 8'd11, 8'd0, 8'd0}, 11, 1'b1);
        waitDrain();

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
